// File: rtl/mips_isa_pkg.sv
// Shared MIPS opcode constants, instruction formats, and encoder request/state types.
// Imported by the control unit decoder and the instruction encoder.
package mips_isa_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ADDIU = 6'b001001;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_SLTIU = 6'b001011;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J, FMT_ILLEGAL} fmt_e;

   typedef enum logic [1:0] {ST_IDLE, ST_ENC, ST_WRITE, ST_FULL} enc_state_e;

   typedef struct packed {
      logic [5:0]  op;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
      logic [15:0] imm;
      logic [25:0] target;
   } req_fields_t;

   function automatic fmt_e op_format(input logic [5:0] op);
      case (op)
         OP_RTYPE:      return FMT_R;
         OP_J, OP_JAL:  return FMT_J;
         OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
         OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI:
                        return FMT_I;
         default:       return FMT_ILLEGAL;
      endcase
   endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(parameter int AW = 8);
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        op;
   logic [4:0]        rs;
   logic [4:0]        rt;
   logic [4:0]        rd;
   logic [4:0]        shamt;
   logic [5:0]        funct;
   logic [15:0]       imm;
   logic [25:0]       target;
   logic              imem_we;
   logic [AW-1:0]     imem_addr;
   logic [31:0]       imem_wdata;

   modport master (
      output req_valid, op, rs, rt, rd, shamt, funct, imm, target,
      input  req_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      input  req_valid, op, rs, rt, rd, shamt, funct, imm, target,
      output req_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/instr_fmt_pack.sv
// Classifies an opcode into R/I/J/illegal and packs the matching 32-bit word.
module instr_fmt_pack
   import mips_isa_pkg::*;
(
   input  req_fields_t fields_i,
   output fmt_e        fmt_o,
   output logic [31:0] word_o
);

   always_comb begin
      fmt_o  = op_format(fields_i.op);
      word_o = '0;
      case (fmt_o)
         FMT_R:   word_o = {fields_i.op, fields_i.rs, fields_i.rt, fields_i.rd,
                            fields_i.shamt, fields_i.funct};
         FMT_I:   word_o = {fields_i.op, fields_i.rs, fields_i.rt, fields_i.imm};
         FMT_J:   word_o = {fields_i.op, fields_i.target};
         default: word_o = '0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Encodes field-level instruction requests into MIPS words and writes them
// sequentially into instruction memory, saturating at DEPTH.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | ready for a request or a base-pointer load
// ST_ENC   | classify latched fields, stage word/address or flag illegal
// ST_WRITE | imem_we high for one cycle, pointer advances
// ST_FULL  | pointer reached DEPTH, only an in-range load_base exits
module instr_encoder
   import mips_isa_pkg::*;
#(
   parameter int AW    = 8,
   parameter int DEPTH = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   instr_encoder_if.slave    bus,
   input  logic              load_base_i,
   input  logic [AW-1:0]     base_addr_i,
   output logic [AW-1:0]     wr_ptr_o,
   output logic              full_o,
   output logic              err_illegal_o,
   input  logic              clr_err_i
);

   // One extra pointer bit so that DEPTH == 2**AW is representable.
   localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

   enc_state_e     state_q, state_d;
   req_fields_t    fields_q, fields_d;
   logic [AW:0]    ptr_q, ptr_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic           err_q, err_d;
   logic           ready_c;
   logic [AW:0]    ptr_inc;
   logic [AW:0]    base_ext;
   fmt_e           fmt;
   logic [31:0]    word;

   instr_fmt_pack u_pack (
      .fields_i (fields_q),
      .fmt_o    (fmt),
      .word_o   (word)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         fields_q <= '0;
         ptr_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         fields_q <= fields_d;
         ptr_q    <= ptr_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      fields_d = fields_q;
      ptr_d    = ptr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      ready_c  = 1'b0;
      ptr_inc  = ptr_q + 1'b1;
      base_ext = {1'b0, base_addr_i};

      if (clr_err_i) err_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ready_c = !load_base_i;
            if (load_base_i) begin
               ptr_d = base_ext;
            end else if (bus.req_valid) begin
               fields_d = '{op: bus.op, rs: bus.rs, rt: bus.rt, rd: bus.rd,
                            shamt: bus.shamt, funct: bus.funct,
                            imm: bus.imm, target: bus.target};
               state_d  = ST_ENC;
            end
         end
         ST_ENC: begin
            // An illegal opcode overrides a coincident clr_err.
            if (fmt == FMT_ILLEGAL) begin
               err_d   = 1'b1;
               state_d = ST_IDLE;
            end else begin
               wdata_d = word;
               addr_d  = ptr_q[AW-1:0];
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            ptr_d   = ptr_inc;
            state_d = (ptr_inc == DEPTH_P) ? ST_FULL : ST_IDLE;
         end
         ST_FULL: begin
            if (load_base_i && (base_ext < DEPTH_P)) begin
               ptr_d   = base_ext;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Gated by rst_n so ready and the write strobe fall the moment reset asserts.
   assign bus.req_ready  = rst_n & ready_c;
   assign bus.imem_we    = (state_q == ST_WRITE);
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign wr_ptr_o       = ptr_q[AW-1:0];
   assign full_o         = (state_q == ST_FULL);
   assign err_illegal_o  = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// requests checked against a field-level encoding model.
module tb_instr_encoder;

   localparam int AW    = 8;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_base;
   logic [AW-1:0] base_addr;
   logic [AW-1:0] wr_ptr;
   logic          full;
   logic          err_illegal;
   logic          clr_err;

   int vectors = 0;
   int miscompares = 0;

   int          m_ptr;
   bit          m_err;
   logic [31:0] seen_w;
   logic [31:0] seen_a;

   logic [5:0] legal_ops [14] = '{6'd0, 6'd2, 6'd3, 6'd35, 6'd43, 6'd4, 6'd5,
                                  6'd8, 6'd9, 6'd10, 6'd11, 6'd12, 6'd13, 6'd14};

   instr_encoder_if #(.AW(AW)) bus ();

   instr_encoder #(.AW(AW), .DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus),
      .load_base_i   (load_base),
      .base_addr_i   (base_addr),
      .wr_ptr_o      (wr_ptr),
      .full_o        (full),
      .err_illegal_o (err_illegal),
      .clr_err_i     (clr_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit ref_encode(input logic [5:0] op, input logic [4:0] rs, rt, rd, sh,
                                     input logic [5:0] fn, input logic [15:0] imm,
                                     input logic [25:0] tg, output logic [31:0] w);
      w = 32'(op) << 26;
      if (op == 6'd0) begin
         w = w | (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
         return 1'b1;
      end else if (op inside {6'd2, 6'd3}) begin
         w = w | 32'(tg);
         return 1'b1;
      end else if (op inside {6'd35, 6'd43, 6'd4, 6'd5, [6'd8:6'd14]}) begin
         w = w | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
         return 1'b1;
      end
      w = '0;
      return 1'b0;
   endfunction

   task automatic scramble();
      bus.op = 6'($urandom); bus.rs = 5'($urandom); bus.rt = 5'($urandom);
      bus.rd = 5'($urandom); bus.shamt = 5'($urandom); bus.funct = 6'($urandom);
      bus.imm = 16'($urandom); bus.target = 26'($urandom);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, "_ready"}, bus.req_ready, 0);
      chk({tag, "_we"}, bus.imem_we, 0);
      chk({tag, "_addr"}, bus.imem_addr, 0);
      chk({tag, "_wdata"}, bus.imem_wdata, 0);
      chk({tag, "_wr_ptr"}, wr_ptr, 0);
      chk({tag, "_full"}, full, 0);
      chk({tag, "_err"}, err_illegal, 0);
   endtask

   // Entered near a negedge with the DUT in IDLE; returns at a negedge after the request settles.
   task automatic send(input logic [5:0] op_v, input logic [4:0] rs_v, rt_v, rd_v, sh_v,
                       input logic [5:0] fn_v, input logic [15:0] imm_v, input logic [25:0] tg_v,
                       input bit clr_enc, input bit noise);
      logic [31:0] exp_w;
      bit legal;
      int budget;
      legal = ref_encode(op_v, rs_v, rt_v, rd_v, sh_v, fn_v, imm_v, tg_v, exp_w);
      bus.op = op_v; bus.rs = rs_v; bus.rt = rt_v; bus.rd = rd_v; bus.shamt = sh_v;
      bus.funct = fn_v; bus.imm = imm_v; bus.target = tg_v;
      bus.req_valid = 1'b1;
      #1;
      budget = 0;
      while (!bus.req_ready && budget < 20) begin
         @(negedge clk); #1; budget++;
      end
      chk("accept_wait", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      scramble();
      clr_err = clr_enc;
      load_base = noise;
      base_addr = AW'($urandom);
      @(negedge clk);
      chk("enc_ready", bus.req_ready, 0);
      chk("enc_we", bus.imem_we, 0);
      @(posedge clk); #1;
      clr_err = 1'b0;
      if (!legal) m_err = 1'b1;
      else if (clr_enc) m_err = 1'b0;
      if (legal) begin
         @(negedge clk);
         seen_w = bus.imem_wdata;
         seen_a = 32'(bus.imem_addr);
         chk("wr_we", bus.imem_we, 1);
         chk("wr_ready", bus.req_ready, 0);
         chk("wr_addr", bus.imem_addr, 32'(m_ptr % 256));
         chk("wr_wdata", bus.imem_wdata, exp_w);
         @(posedge clk); #1;
         load_base = 1'b0;
         m_ptr++;
      end else begin
         load_base = 1'b0;
      end
      @(negedge clk);
      chk("post_we", bus.imem_we, 0);
      chk("post_wr_ptr", wr_ptr, 32'(m_ptr % 256));
      chk("post_full", full, (m_ptr == DEPTH));
      chk("post_ready", bus.req_ready, (m_ptr != DEPTH));
      chk("post_err", err_illegal, m_err);
   endtask

   // Drives load_base for one cycle from a negedge; optionally with req_valid alongside.
   task automatic load(input logic [AW-1:0] base, input bit with_valid);
      load_base = 1'b1;
      base_addr = base;
      bus.req_valid = with_valid;
      #1;
      chk("load_ready", bus.req_ready, 0);
      @(posedge clk); #1;
      load_base = 1'b0;
      bus.req_valid = 1'b0;
      m_ptr = int'(base);
      @(negedge clk);
      chk("load_wr_ptr", wr_ptr, 32'(base));
      chk("load_full", full, 0);
      chk("load_ready_after", bus.req_ready, 1);
      chk("load_we", bus.imem_we, 0);
   endtask

   initial begin
      rst_n = 1'b0; load_base = 1'b0; base_addr = '0; clr_err = 1'b0;
      bus.req_valid = 1'b0;
      scramble();
      m_ptr = 0; m_err = 1'b0;
      #2;
      reset_vals("rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // R add $3,$1,$2
      send(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'h0, 26'h0, 0, 0);
      chk("r_word", seen_w, 32'h00221820);
      chk("r_addr", seen_a, 0);
      // lw $8,4($29) and jal 0x0100000
      send(6'b100011, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0004, 26'h0, 0, 0);
      chk("lw_word", seen_w, 32'h8FA80004);
      send(6'b000011, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'h0, 26'h0100000, 0, 0);
      chk("jal_word", seen_w, 32'h0C100000);

      // Illegal, explicit clear, then clear colliding with a second illegal
      send(6'b111111, 5'd1, 5'd1, 5'd1, 5'd1, 6'd1, 16'h1, 26'h1, 0, 0);
      clr_err = 1'b1;
      @(posedge clk); #1;
      clr_err = 1'b0;
      m_err = 1'b0;
      @(negedge clk);
      chk("clr_err", err_illegal, 0);
      send(6'b111111, 5'd2, 5'd2, 5'd2, 5'd2, 6'd2, 16'h2, 26'h2, 1, 0);
      chk("set_wins", err_illegal, 1);

      // Randomized traffic, with stray load_base during ENC/WRITE
      for (int i = 0; i < 40; i++) begin
         logic [5:0] op_r;
         if ($urandom_range(0, 9) < 8) op_r = legal_ops[$urandom_range(0, 13)];
         else op_r = 6'($urandom);
         send(op_r, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
              16'($urandom), 26'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom));
      end

      // Fill to the top, then recover with load_base
      load(8'hFE, 0);
      send(6'b001000, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 0, 0);
      chk("addi_word", seen_w, 32'h20090005);
      chk("addi_addr0", seen_a, 32'hFE);
      send(6'b001000, 5'd0, 5'd9, 5'd0, 5'd0, 6'd0, 16'h0005, 26'h0, 0, 0);
      chk("addi_addr1", seen_a, 32'hFF);
      chk("full_set", full, 1);
      bus.req_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("full_no_ready", bus.req_ready, 0);
         chk("full_no_we", bus.imem_we, 0);
      end
      bus.req_valid = 1'b0;
      load(8'h10, 0);

      // load_base wins over a coincident request
      load(8'h40, 1);
      send(6'b101011, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h8000, 26'h0, 0, 0);
      chk("sw_addr", seen_a, 32'h40);

      // Reset asserted during WRITE drops the strobe without a clock edge
      bus.op = 6'b001101; bus.rs = 5'd1; bus.rt = 5'd2; bus.imm = 16'hBEEF;
      bus.req_valid = 1'b1;
      #1;
      chk("rw_ready", bus.req_ready, 1);
      @(posedge clk); #1;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rw_we_before", bus.imem_we, 1);
      #2 rst_n = 1'b0;
      #1;
      reset_vals("async_rst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_ptr = 0; m_err = 1'b0;
      send(6'b001101, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'h0, 0, 0);
      chk("post_rst_addr", seen_a, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
